// File: rtl/core_pipe_fetch_ctrl_pkg.sv
// Shared core definitions for the instruction fetch controller:
// fetch width, fetch buffer capacity and the controller state encoding.
package core_pipe_fetch_ctrl_pkg;

   localparam int unsigned FC_XLEN        = 64;
   localparam int unsigned FC_BUF_BYTES   = 16;
   localparam int unsigned FC_FETCH_BYTES = 8;

   typedef enum logic [1:0] {
      FC_ST_FETCH   = 2'b00,
      FC_ST_DISCARD = 2'b01,
      FC_ST_HALT    = 2'b10
   } fc_state_e;

   function automatic logic [FC_XLEN-1:0] fc_align8(input logic [FC_XLEN-1:0] addr);
      return {addr[FC_XLEN-1:3], 3'b000};
   endfunction

endpackage

// File: rtl/core_pipe_fetch_ctrl_ctr.sv
// Outstanding-request counter (oc) and discard counter (dc) for the fetch controller.
// The post-update values are exported so the parent can act on them in the same cycle.
module core_pipe_fetch_ctrl_ctr #(
   parameter int unsigned MAX = 2,
   parameter int unsigned W   = 2
) (
   input  logic         g_clk,
   input  logic         g_resetn,
   input  logic         inc,
   input  logic         dec,
   input  logic         load,
   output logic [W-1:0] oc_q,
   output logic [W-1:0] dc_q,
   output logic [W-1:0] oc_d,
   output logic [W-1:0] dc_d
);

   localparam logic [W-1:0] CTR_ZERO = {W{1'b0}};
   localparam logic [W-1:0] CTR_ONE  = W'(1'b1);
   localparam logic [W-1:0] CTR_MAX  = W'(MAX);

   // Next-value logic; a redirect loads dc with the already-updated oc.
   always_comb begin
      oc_d = oc_q;
      dc_d = dc_q;
      if (inc && !dec && (oc_q != CTR_MAX)) begin
         oc_d = oc_q + CTR_ONE;
      end else if (dec && !inc && (oc_q != CTR_ZERO)) begin
         oc_d = oc_q - CTR_ONE;
      end else begin
         oc_d = oc_q;
      end
      if (load) begin
         dc_d = oc_d;
      end else if (dec && (dc_q != CTR_ZERO)) begin
         dc_d = dc_q - CTR_ONE;
      end else begin
         dc_d = dc_q;
      end
   end

   // Counter registers.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         oc_q <= CTR_ZERO;
         dc_q <= CTR_ZERO;
      end else begin
         oc_q <= oc_d;
         dc_q <= dc_d;
      end
   end

endmodule

// File: rtl/core_pipe_fetch_ctrl.sv
// Instruction fetch controller: issues aligned 8-byte memory fetches, tracks
// outstanding responses, drops stale ones after a redirect and drives buffer fill.
module core_pipe_fetch_ctrl
   import core_pipe_fetch_ctrl_pkg::*;
#(
   parameter logic [63:0] FC_RESET_ADDR      = 64'h0000_0000_8000_0000,
   parameter int unsigned FC_MAX_OUTSTANDING = 2
) (
   input  logic                g_clk,
   input  logic                g_resetn,
   input  logic                cf_req,
   input  logic [FC_XLEN-1:0]  cf_target,
   output logic                imem_req,
   output logic [FC_XLEN-1:0]  imem_addr,
   input  logic                imem_gnt,
   input  logic                imem_recv,
   input  logic [FC_XLEN-1:0]  imem_rdata,
   input  logic                imem_error,
   input  logic [4:0]          buf_n_depth,
   output logic                buf_flush,
   output logic                fill_en,
   output logic                fill_2,
   output logic                fill_4,
   output logic                fill_6,
   output logic                fill_8,
   output logic [FC_XLEN-1:0]  fill_data,
   output logic                fill_error
);

   localparam int unsigned      OCW      = (FC_MAX_OUTSTANDING < 1) ? 1 : $clog2(FC_MAX_OUTSTANDING + 1);
   localparam logic [OCW-1:0]   CTR_ZERO = {OCW{1'b0}};
   localparam logic [OCW-1:0]   CTR_MAX  = OCW'(FC_MAX_OUTSTANDING);

   fc_state_e          state_q, state_d;
   logic [FC_XLEN-1:0] fa_q, fa_d;
   logic [1:0]         off_q, off_d;
   logic [OCW-1:0]     oc_q, dc_q, oc_d, dc_d;
   logic [31:0]        need_s;
   logic               req_s, commit_s, accept_s;
   logic               unused_s;

   assign unused_s = cf_target[0];

   // Buffer bytes required if one more fetch were issued now.
   assign need_s   = 32'(buf_n_depth) + 32'(FC_FETCH_BYTES) * (32'(oc_q) + 32'd1);
   assign commit_s = req_s && imem_gnt;
   // A response fills only when nothing older is still being discarded.
   assign accept_s = g_resetn && imem_recv && !cf_req && (dc_q == CTR_ZERO) && (state_q == FC_ST_FETCH);

   core_pipe_fetch_ctrl_ctr #(
      .MAX (FC_MAX_OUTSTANDING),
      .W   (OCW)
   ) u_ctr (
      .g_clk    (g_clk),
      .g_resetn (g_resetn),
      .inc      (commit_s),
      .dec      (imem_recv),
      .load     (cf_req),
      .oc_q     (oc_q),
      .dc_q     (dc_q),
      .oc_d     (oc_d),
      .dc_d     (dc_d)
   );

   // Request, flush and fill controls, all combinational from this cycle's inputs.
   always_comb begin
      req_s     = 1'b0;
      buf_flush = 1'b0;
      fill_en   = 1'b0;
      fill_2    = 1'b0;
      fill_4    = 1'b0;
      fill_6    = 1'b0;
      fill_8    = 1'b0;
      if (g_resetn) begin
         req_s     = (state_q != FC_ST_HALT) && !cf_req && (oc_q < CTR_MAX)
                     && (need_s <= 32'(FC_BUF_BYTES));
         buf_flush = cf_req;
         fill_en   = accept_s;
         if (accept_s) begin
            case (off_q)
               2'd0:    fill_8 = 1'b1;
               2'd1:    fill_6 = 1'b1;
               2'd2:    fill_4 = 1'b1;
               2'd3:    fill_2 = 1'b1;
               default: fill_8 = 1'b0;
            endcase
         end else begin
            fill_8 = 1'b0;
         end
      end else begin
         req_s = 1'b0;
      end
   end

   assign imem_req   = req_s;
   assign imem_addr  = fa_q;
   assign fill_data  = imem_rdata;
   assign fill_error = imem_error;

   // Fetch address, offset and state sequencing.
   always_comb begin
      state_d = state_q;
      fa_d    = fa_q;
      off_d   = off_q;
      if (cf_req) begin
         fa_d    = fc_align8(cf_target);
         off_d   = cf_target[2:1];
         state_d = (oc_d != CTR_ZERO) ? FC_ST_DISCARD : FC_ST_FETCH;
      end else begin
         if (commit_s) begin
            fa_d = fa_q + 64'd8;
         end else begin
            fa_d = fa_q;
         end
         if (accept_s) begin
            off_d   = 2'b00;
            state_d = imem_error ? FC_ST_HALT : FC_ST_FETCH;
         end else if ((state_q == FC_ST_DISCARD) && (dc_d == CTR_ZERO)) begin
            state_d = FC_ST_FETCH;
         end else begin
            state_d = state_q;
         end
      end
   end

   // State registers.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state_q <= FC_ST_FETCH;
         fa_q    <= fc_align8(FC_RESET_ADDR);
         off_q   <= FC_RESET_ADDR[2:1];
      end else begin
         state_q <= state_d;
         fa_q    <= fa_d;
         off_q   <= off_d;
      end
   end

endmodule
